id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 18 +
 rtl/id_ex_stage_load_use.sv | 20 ++
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared register-number constants and ID/EX control bundle layout.
package id_ex_stage_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;
    localparam int         ALUOP_W  = 3;

    typedef struct packed {
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               alusrc;
        logic               jal;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_load_use.sv
// load_use_detector: flags a load in EX whose rt is read by the ID instruction (LOAD_USE_DETECT_EN enables).
module load_use_detector
    import id_ex_stage_pkg::*;
(
    input  logic       i_id_ex_mem_read,
    input  logic [4:0] i_id_ex_rt,
    input  logic [4:0] i_if_id_rs,
    input  logic [4:0] i_if_id_rt,
    output logic       o_hazard
);

`ifdef LOAD_USE_DETECT_EN
    assign o_hazard = i_id_ex_mem_read && (i_id_ex_rt != REG_ZERO) &&
                      ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
`else
    // Software schedules NOPs after loads; inputs are folded away to a constant.
    assign o_hazard = 1'b0 & (|{i_id_ex_mem_read, i_id_ex_rt, i_if_id_rs, i_if_id_rt});
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and bubble insertion (LOAD_USE_DETECT_EN enables detection).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         IF_ID_Rs,
    input  logic [4:0]         IF_ID_Rt,
    input  logic [4:0]         IF_ID_Rd,
    input  logic [N-1:0]       ReadData1,
    input  logic [N-1:0]       ReadData2,
    input  logic [N-1:0]       Immediate,
    input  logic [N-1:0]       PC_4,
    input  logic               RegWrite,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               MemtoReg,
    input  logic               ALUSrc,
    input  logic               RegDst,
    input  logic               Jal,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic               Flush,
    output logic [4:0]         ID_EX_Rs,
    output logic [4:0]         ID_EX_Rt,
    output logic [4:0]         ID_EX_WriteReg,
    output logic [N-1:0]       ID_EX_ReadData1,
    output logic [N-1:0]       ID_EX_ReadData2,
    output logic [N-1:0]       ID_EX_Immediate,
    output logic [N-1:0]       ID_EX_PC_4,
    output logic               ID_EX_RegWrite,
    output logic               ID_EX_MemRead,
    output logic               ID_EX_MemWrite,
    output logic               ID_EX_MemtoReg,
    output logic               ID_EX_ALUSrc,
    output logic               ID_EX_Jal,
    output logic [ALUOP_W-1:0] ID_EX_ALUOp,
    output logic               ID_EX_Valid,
    output logic               Stall
);

    logic [4:0]   r_rs, r_rt, r_write_reg;
    logic [N-1:0] r_rd1, r_rd2, r_imm, r_pc4;
    ctrl_t        r_ctrl;
    logic         r_valid;
    logic         w_hazard;
    logic [4:0]   w_write_reg;
    ctrl_t        w_ctrl;

    load_use_detector u_load_use (
        .i_id_ex_mem_read (r_ctrl.memread),
        .i_id_ex_rt       (r_rt),
        .i_if_id_rs       (IF_ID_Rs),
        .i_if_id_rt       (IF_ID_Rt),
        .o_hazard         (w_hazard)
    );

    // A flushed instruction is discarded anyway, so it must not hold the front end.
    assign Stall       = w_hazard & ~Flush;
    assign w_write_reg = Jal ? REG_RA : (RegDst ? IF_ID_Rd : IF_ID_Rt);
    assign w_ctrl      = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Jal, ALUOp};

    always_ff @(posedge clk) begin
        if (reset || Flush || w_hazard) begin
            r_rs        <= REG_ZERO;
            r_rt        <= REG_ZERO;
            r_write_reg <= REG_ZERO;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_pc4       <= '0;
            r_ctrl      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_rs        <= IF_ID_Rs;
            r_rt        <= IF_ID_Rt;
            r_write_reg <= w_write_reg;
            r_rd1       <= ReadData1;
            r_rd2       <= ReadData2;
            r_imm       <= Immediate;
            r_pc4       <= PC_4;
            r_ctrl      <= w_ctrl;
            r_valid     <= 1'b1;
        end
    end

    assign ID_EX_Rs        = r_rs;
    assign ID_EX_Rt        = r_rt;
    assign ID_EX_WriteReg  = r_write_reg;
    assign ID_EX_ReadData1 = r_rd1;
    assign ID_EX_ReadData2 = r_rd2;
    assign ID_EX_Immediate = r_imm;
    assign ID_EX_PC_4      = r_pc4;
    assign ID_EX_RegWrite  = r_ctrl.regwrite;
    assign ID_EX_MemRead   = r_ctrl.memread;
    assign ID_EX_MemWrite  = r_ctrl.memwrite;
    assign ID_EX_MemtoReg  = r_ctrl.memtoreg;
    assign ID_EX_ALUSrc    = r_ctrl.alusrc;
    assign ID_EX_Jal       = r_ctrl.jal;
    assign ID_EX_ALUOp     = r_ctrl.aluop;
    assign ID_EX_Valid     = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized self-checking bench for id_ex_stage against a pipeline-register model.
module tb_id_ex_stage;

`ifdef LOAD_USE_DETECT_EN
    localparam bit DETECT = 1'b1;
`else
    localparam bit DETECT = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rs, rt, wr;
        logic [31:0] rd1, rd2, imm, pc4;
        logic        regwrite, memread, memwrite, memtoreg, alusrc, jal;
        logic [2:0]  aluop;
        logic        valid;
    } st_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [31:0] rd1 = '0, rd2 = '0, imm = '0, pc4 = '0;
    logic        regwrite = 0, memread = 0, memwrite = 0, memtoreg = 0, alusrc = 0, regdst = 0, jal = 0;
    logic [2:0]  aluop = '0;
    logic        flush = 1'b0;

    logic [4:0]  o_rs, o_rt, o_wr;
    logic [31:0] o_rd1, o_rd2, o_imm, o_pc4;
    logic        o_regwrite, o_memread, o_memwrite, o_memtoreg, o_alusrc, o_jal, o_valid, o_stall;
    logic [2:0]  o_aluop;

    st_t act, m;
    int  tests = 0, fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.N(32)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_Rd(rd),
        .ReadData1(rd1), .ReadData2(rd2), .Immediate(imm), .PC_4(pc4),
        .RegWrite(regwrite), .MemRead(memread), .MemWrite(memwrite), .MemtoReg(memtoreg),
        .ALUSrc(alusrc), .RegDst(regdst), .Jal(jal), .ALUOp(aluop), .Flush(flush),
        .ID_EX_Rs(o_rs), .ID_EX_Rt(o_rt), .ID_EX_WriteReg(o_wr),
        .ID_EX_ReadData1(o_rd1), .ID_EX_ReadData2(o_rd2), .ID_EX_Immediate(o_imm), .ID_EX_PC_4(o_pc4),
        .ID_EX_RegWrite(o_regwrite), .ID_EX_MemRead(o_memread), .ID_EX_MemWrite(o_memwrite),
        .ID_EX_MemtoReg(o_memtoreg), .ID_EX_ALUSrc(o_alusrc), .ID_EX_Jal(o_jal),
        .ID_EX_ALUOp(o_aluop), .ID_EX_Valid(o_valid), .Stall(o_stall)
    );

    assign act = {o_rs, o_rt, o_wr, o_rd1, o_rd2, o_imm, o_pc4,
                  o_regwrite, o_memread, o_memwrite, o_memtoreg, o_alusrc, o_jal, o_aluop, o_valid};

    // What the ID instruction looks like once it sits in EX.
    function automatic st_t issued();
        st_t s;
        s.rs = rs;
        s.rt = rt;
        if (jal) s.wr = 5'd31;
        else if (regdst) s.wr = rd;
        else s.wr = rt;
        s.rd1 = rd1; s.rd2 = rd2; s.imm = imm; s.pc4 = pc4;
        s.regwrite = regwrite; s.memread = memread; s.memwrite = memwrite;
        s.memtoreg = memtoreg; s.alusrc = alusrc; s.jal = jal; s.aluop = aluop;
        s.valid = 1'b1;
        return s;
    endfunction

    function automatic bit load_use();
        return DETECT && m.valid && m.memread && m.rt != 5'd0 && (m.rt == rs || m.rt == rt);
    endfunction

    function automatic bit exp_stall();
        return load_use() && !flush;
    endfunction

    task automatic tick();
        st_t nxt;
        nxt = (reset || flush || load_use()) ? st_t'(0) : issued();
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic rand_inputs(input int max_reg);
        rs = 5'($urandom_range(0, max_reg));
        rt = 5'($urandom_range(0, max_reg));
        rd = 5'($urandom_range(0, 31));
        rd1 = $urandom; rd2 = $urandom; imm = $urandom; pc4 = $urandom;
        {regwrite, memread, memwrite, memtoreg, alusrc, regdst, jal} = 7'($urandom);
        aluop = 3'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs(31);
            tick();
            tests++;
            if (act !== '0 || o_stall !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: got %h stall=%b, want 0 stall=0", act, o_stall);
            end
        end
        reset = 1'b0;
        flush = 1'b0;
        rand_inputs(31);
        tick();
        tests++;
        if (act !== m || o_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: got %h, want %h", act, m);
        end
    endtask

    task automatic test_load_use();
        rand_inputs(31);
        memread = 1'b1; rt = 5'd8; jal = 1'b0;
        tick();
        rand_inputs(31);
        memread = 1'b0; rs = 5'd8; rt = 5'd9;
        #1;
        tests++;
        if (o_stall !== DETECT) begin
            fails++;
            $display("FAIL load_use_stall: got %b, want %b", o_stall, DETECT);
        end
        tick();
        tests++;
        if (act !== m || o_valid !== !DETECT || o_stall !== 1'b0) begin
            fails++;
            $display("FAIL load_use_bubble: got %h valid=%b stall=%b, want %h", act, o_valid, o_stall, m);
        end
        tick();
        tests++;
        if (act !== m || o_valid !== 1'b1 || o_rs !== 5'd8) begin
            fails++;
            $display("FAIL load_use_release: got %h, want %h", act, m);
        end
    endtask

    task automatic test_zero_reg();
        rand_inputs(31);
        memread = 1'b1; rt = 5'd0;
        tick();
        rand_inputs(31);
        rs = 5'd0; rt = 5'd0;
        #1;
        tests++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL zero_reg_stall: got %b, want 0", o_stall);
        end
        tick();
        tests++;
        if (act !== m || o_valid !== 1'b1) begin
            fails++;
            $display("FAIL zero_reg_load: got %h, want %h", act, m);
        end
    endtask

    task automatic test_writereg();
        logic [4:0] want [3] = '{5'd31, 5'd5, 5'd9};
        for (int i = 0; i < 3; i++) begin
            rand_inputs(31);
            memread = 1'b0; rd = 5'd5; rt = 5'd9; rs = 5'd1;
            jal = (i == 0); regdst = (i < 2);
            tick();
            tests++;
            if (o_wr !== want[i] || act !== m) begin
                fails++;
                $display("FAIL writereg_%0d: got %0d, want %0d", i, o_wr, want[i]);
            end
        end
    endtask

    task automatic test_flush();
        rand_inputs(31);
        memread = 1'b1; rt = 5'd8;
        tick();
        rand_inputs(31);
        rs = 5'd8; flush = 1'b1;
        #1;
        tests++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_hazard_stall: got %b, want 0", o_stall);
        end
        tick();
        tests++;
        if (act !== '0) begin
            fails++;
            $display("FAIL flush_hazard_bubble: got %h, want 0", act);
        end
        rand_inputs(31);
        rd1 = 32'hDEADBEEF;
        tick();
        tests++;
        if (o_rd1 !== 32'h0 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_data: got rd1=%h valid=%b, want 0", o_rd1, o_valid);
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        rand_inputs(31);
        memread = 1'b1; rt = 5'd12;
        tick();
        rand_inputs(31);
        rt = 5'd12; reset = 1'b1;
        #1;
        tests++;
        if (o_stall !== DETECT) begin
            fails++;
            $display("FAIL reset_mid_stall_pre: got %b, want %b", o_stall, DETECT);
        end
        tick();
        tests++;
        if (act !== '0 || o_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_stall_post: got %h stall=%b, want 0", act, o_stall);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(7);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 31) == 0);
            #1;
            tests++;
            if (o_stall !== exp_stall()) begin
                fails++;
                $display("FAIL random_stall[%0d]: got %b, want %b", i, o_stall, exp_stall());
            end
            tick();
            tests++;
            if (act !== m) begin
                fails++;
                $display("FAIL random_regs[%0d]: got %h, want %h", i, act, m);
            end
        end
        reset = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        rand_inputs(31);
        memread = 1'b1; rt = 5'd3; rs = 5'd1;
        tick();
        rand_inputs(31);
        memread = 1'b1; rt = 5'd4; rs = 5'd2;
        #1;
        tests++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL b2b_independent: got %b, want 0", o_stall);
        end
        tick();
        rand_inputs(31);
        memread = 1'b0; rs = 5'd4; rt = 5'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (o_stall === 1'b1) stalls++;
            tick();
            if (o_valid === 1'b1 && o_rs === 5'd4) break;
        end
        tests++;
        if (stalls != int'(DETECT) || act !== m) begin
            fails++;
            $display("FAIL b2b_dependent: got %0d stalls, want %0d", stalls, int'(DETECT));
        end
    endtask

    initial begin
        m = '0;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_writereg();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
